// File: rtl/ups_pkg.sv
// rtl/ups_pkg.sv - shared types, mode codes and loopback alignment for the UPS controller
package ups_pkg;

  // Controller states shared by the sequencer and anything observing it
  typedef enum logic [3:0] {
    IDLE,
    TEST_LB,
    TEST_DAC,
    RUN_STAGE,
    RUN_PRE,
    RUN_PULSE,
    RUN_GAP,
    RUN_DONE,
    ABORT
  } state_t;

  // Values of the 32-bit mode register; anything else behaves as idle
  localparam logic [31:0] MODE_IDLE = 32'd0;
  localparam logic [31:0] MODE_LB   = 32'd1;
  localparam logic [31:0] MODE_DAC  = 32'd2;
  localparam logic [31:0] MODE_RUN  = 32'd3;

  // Width of the pulse-repetition counter (matches cfg_loops)
  localparam int LOOP_W = 16;

  // Left-justify a src_w-bit sample in 32 bits, then take the top dst_w bits.
  // A wider source loses its LSBs, a narrower one gets zero-filled LSBs.
  // Both widths must be in 1..32 and the caller zero-extends the sample.
  function automatic logic [31:0] align_msb(input logic [31:0] sample,
                                            input int src_w,
                                            input int dst_w);
    logic [31:0] left;
    left = sample << (32 - src_w);
    return left >> (32 - dst_w);
  endfunction

endpackage

// File: rtl/ups_phase_timer.sv
// rtl/ups_phase_timer.sv - loadable phase-length down-counter with single-cycle expire
module ups_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_len_eff;

  // A programmed length of zero still occupies one cycle
  assign w_len_eff = (i_len == '0) ? CNT_W'(1) : i_len;

  // Count down to zero and park there; a load restarts the phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= w_len_eff;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Last cycle of the phase: the sequencer moves on at the following edge
  assign o_expire = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/ups_ctrl_mc.sv
// rtl/ups_ctrl_mc.sv - multi-channel UPS controller: idle, loopback, DAC test and timed pulse run
module ups_ctrl_mc
  import ups_pkg::*;
#(
  parameter int NUM_DAC = 2,
  parameter int DATA_W  = 12,
  parameter int ADC_W   = 12,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               mode,
  input  logic                      mode_update,
  input  logic [NUM_DAC*DATA_W-1:0] test_data,
  input  logic [NUM_DAC-1:0]        test_dv,
  input  logic [ADC_W-1:0]          adc,
  input  logic                      adc_dv,
  input  logic [DATA_W-1:0]         cfg_base,
  input  logic [DATA_W-1:0]         cfg_pre_lvl,
  input  logic [DATA_W-1:0]         cfg_pulse_lvl,
  input  logic [CNT_W-1:0]          cfg_pre_len,
  input  logic [CNT_W-1:0]          cfg_pulse_len,
  input  logic [CNT_W-1:0]          cfg_gap_len,
  input  logic [LOOP_W-1:0]         cfg_loops,
  input  logic [NUM_DAC-1:0]        cfg_chan_mask,
  output logic [NUM_DAC*DATA_W-1:0] dac,
  output logic [NUM_DAC-1:0]        dac_dv,
  output logic                      busy,
  output logic                      run_done
);

  state_t                    r_state;
  logic [NUM_DAC*DATA_W-1:0] r_dac;
  logic [NUM_DAC-1:0]        r_dac_dv;
  logic                      r_busy;
  logic                      r_run_done;

  // Run configuration captured at staging so live cfg edits cannot disturb a run
  logic [DATA_W-1:0]         r_base;
  logic [DATA_W-1:0]         r_pre_lvl;
  logic [DATA_W-1:0]         r_pulse_lvl;
  logic [CNT_W-1:0]          r_pre_len;
  logic [CNT_W-1:0]          r_pulse_len;
  logic [CNT_W-1:0]          r_gap_len;
  logic [NUM_DAC-1:0]        r_mask;
  logic [LOOP_W-1:0]         r_loops_left;
  logic                      r_loop_inf;

  logic [DATA_W-1:0]         w_lb;
  logic                      w_expire;
  logic                      w_last_loop;
  logic                      w_phase_go;
  logic [DATA_W-1:0]         w_phase_lvl;
  logic [NUM_DAC-1:0]        w_phase_mask;
  logic                      w_tmr_load;
  logic [CNT_W-1:0]          w_tmr_len;

  assign w_lb = DATA_W'(align_msb(32'(adc), ADC_W, DATA_W));

  // The gap just ending is the final one only for a finite loop count
  assign w_last_loop = !r_loop_inf && (r_loops_left == LOOP_W'(1));

  // At staging the shadows are not yet loaded, so use the live mask then
  assign w_phase_mask = (r_state == IDLE) ? cfg_chan_mask : r_mask;

  // Decide whether this edge enters a run phase, its level and the timer reload
  always_comb begin
    w_phase_go  = 1'b0;
    w_phase_lvl = r_base;
    w_tmr_load  = 1'b0;
    w_tmr_len   = r_pre_len;
    if (!mode_update) begin
      case (r_state)
        IDLE: begin
          if (mode == MODE_RUN) begin
            w_phase_go  = 1'b1;
            w_phase_lvl = cfg_base;
          end
        end
        RUN_STAGE: begin
          w_phase_go  = 1'b1;
          w_phase_lvl = r_pre_lvl;
          w_tmr_load  = 1'b1;
          w_tmr_len   = r_pre_len;
        end
        RUN_PRE: begin
          if (w_expire) begin
            w_phase_go  = 1'b1;
            w_phase_lvl = r_pulse_lvl;
            w_tmr_load  = 1'b1;
            w_tmr_len   = r_pulse_len;
          end
        end
        RUN_PULSE: begin
          if (w_expire) begin
            w_phase_go  = 1'b1;
            w_phase_lvl = r_base;
            w_tmr_load  = 1'b1;
            w_tmr_len   = r_gap_len;
          end
        end
        RUN_GAP: begin
          if (w_expire && !w_last_loop) begin
            w_phase_go  = 1'b1;
            w_phase_lvl = r_pre_lvl;
            w_tmr_load  = 1'b1;
            w_tmr_len   = r_pre_len;
          end
        end
        default: ;
      endcase
    end
  end

  ups_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (mode_update),
    .i_load   (w_tmr_load),
    .i_len    (w_tmr_len),
    .o_expire (w_expire)
  );

  // Mode sequencer with registered DAC outputs, strobes, busy and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_dac        <= '0;
      r_dac_dv     <= '0;
      r_busy       <= 1'b0;
      r_run_done   <= 1'b0;
      r_base       <= '0;
      r_pre_lvl    <= '0;
      r_pulse_lvl  <= '0;
      r_pre_len    <= '0;
      r_pulse_len  <= '0;
      r_gap_len    <= '0;
      r_mask       <= '0;
      r_loops_left <= '0;
      r_loop_inf   <= 1'b0;
    end else begin
      r_dac_dv   <= '0;
      r_run_done <= 1'b0;

      if (w_phase_go) begin
        for (int i = 0; i < NUM_DAC; i++) begin
          if (w_phase_mask[i]) begin
            r_dac[i*DATA_W +: DATA_W] <= w_phase_lvl;
            r_dac_dv[i]               <= 1'b1;
          end
        end
      end

      if (mode_update) begin
        r_state  <= ABORT;
        r_dac    <= '0;
        r_dac_dv <= '1;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            case (mode)
              MODE_LB:  r_state <= TEST_LB;
              MODE_DAC: r_state <= TEST_DAC;
              MODE_RUN: begin
                r_state      <= RUN_STAGE;
                r_busy       <= 1'b1;
                r_base       <= cfg_base;
                r_pre_lvl    <= cfg_pre_lvl;
                r_pulse_lvl  <= cfg_pulse_lvl;
                r_pre_len    <= cfg_pre_len;
                r_pulse_len  <= cfg_pulse_len;
                r_gap_len    <= cfg_gap_len;
                r_mask       <= cfg_chan_mask;
                r_loops_left <= cfg_loops;
                r_loop_inf   <= (cfg_loops == '0);
              end
              default: r_state <= IDLE;
            endcase
          end
          ABORT: begin
            r_state <= IDLE;
          end
          TEST_LB: begin
            if (adc_dv) begin
              for (int i = 0; i < NUM_DAC; i++) begin
                r_dac[i*DATA_W +: DATA_W] <= w_lb;
              end
              r_dac_dv <= '1;
            end
          end
          TEST_DAC: begin
            for (int i = 0; i < NUM_DAC; i++) begin
              if (test_dv[i]) begin
                r_dac[i*DATA_W +: DATA_W] <= test_data[i*DATA_W +: DATA_W];
                r_dac_dv[i]               <= 1'b1;
              end
            end
          end
          RUN_STAGE: begin
            r_state <= RUN_PRE;
          end
          RUN_PRE: begin
            if (w_expire) r_state <= RUN_PULSE;
          end
          RUN_PULSE: begin
            if (w_expire) r_state <= RUN_GAP;
          end
          RUN_GAP: begin
            if (w_expire) begin
              if (w_last_loop) begin
                r_state    <= RUN_DONE;
                r_busy     <= 1'b0;
                r_run_done <= 1'b1;
              end else begin
                r_state <= RUN_PRE;
                if (!r_loop_inf) r_loops_left <= r_loops_left - LOOP_W'(1);
              end
            end
          end
          RUN_DONE: begin
            r_state <= RUN_DONE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign dac      = r_dac;
  assign dac_dv   = r_dac_dv;
  assign busy     = r_busy;
  assign run_done = r_run_done;

endmodule

// File: doc/ups_ctrl_mc.md
# ups_ctrl_mc

Parametrised multi-channel UPS controller: drives NUM_DAC DAC channels from one of four modes (idle, ADC loopback, per-channel DAC test, timed pulse run). It sits between the mode/config register block and the DAC serialisers, with the ADC capture path feeding loopback. It adds to the single-channel controller a configurable pre-pulse/pulse/gap sequencer with loop count, a channel mask, and a safe-zero on abort.

## Interface
- NUM_DAC, 2, number of DAC channels (1..8)
- DATA_W, 12, DAC sample width
- ADC_W, 12, ADC sample width
- CNT_W, 16, phase-length counter width

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- mode  in  32  0 idle, 1 loopback, 2 DAC test, 3 run; other values idle
- mode_update  in  1  pulse; aborts current activity and re-evaluates mode
- test_data  in  NUM_DAC*DATA_W  per-channel test value, channel i at [i*DATA_W +: DATA_W]
- test_dv  in  NUM_DAC  per-channel test strobe
- adc  in  ADC_W  ADC sample
- adc_dv  in  1  ADC sample valid
- cfg_base, cfg_pre_lvl, cfg_pulse_lvl  in  DATA_W each  baseline, pre-pulse, pulse levels
- cfg_pre_len, cfg_pulse_len, cfg_gap_len  in  CNT_W each  phase lengths in cycles; 0 treated as 1
- cfg_loops  in  16  pulse repetitions; 0 = run until mode_update
- cfg_chan_mask  in  NUM_DAC  channels driven in run mode
- dac  out  NUM_DAC*DATA_W  DAC data, same packing as test_data
- dac_dv  out  NUM_DAC  per-channel DAC strobe
- busy  out  1  high in any run state except RUN_DONE
- run_done  out  1  one-cycle pulse on run completion

## Operation
- States (shared state_t): IDLE, TEST_LB, TEST_DAC, RUN_STAGE, RUN_PRE, RUN_PULSE, RUN_GAP, RUN_DONE, ABORT.
- Reset: state IDLE; dac all 0; dac_dv, busy, run_done 0.
- mode_update (any state): next state ABORT; in ABORT all channels drive 0 with dac_dv all 1 for one cycle, then IDLE. Run progress discarded.
- IDLE: mode 1→TEST_LB, 2→TEST_DAC, 3→RUN_STAGE; else stay. Outputs hold.
- TEST_LB: on adc_dv, every channel gets adc aligned MSB-first (ADC_W>DATA_W: drop LSBs; ADC_W<DATA_W: zero-fill LSBs), all dac_dv 1.
- TEST_DAC: test_dv[i] loads channel i independently; simultaneous strobes all honoured.
- RUN_STAGE (1 cycle): latch all cfg_* into shadow registers; masked channels ← cfg_base with dac_dv. cfg changes after staging have no effect until next run.
- RUN_PRE: masked channels ← pre_lvl on entry, hold pre_len cycles. RUN_PULSE: ← pulse_lvl, pulse_len cycles. RUN_GAP: ← base, gap_len cycles, then decrement loop counter.
- After RUN_GAP: loops remaining → RUN_PRE; counter reached 0 (cfg_loops≠0) → RUN_DONE with run_done pulse. cfg_loops=0 never terminates.
- dac_dv for masked channels pulses one cycle at each phase entry only; unmasked channels never change or strobe in run.
- RUN_DONE: hold base, busy 0, wait for mode_update.

## Timing
- All outputs registered; one-cycle latency: adc_dv/test_dv at cycle n → dac/dac_dv at n+1.
- mode_update at n → ABORT zeros at n+1 → IDLE at n+2; new mode leaves IDLE at n+3.
- Run: stage at cycle s; pre entry s+1; pulse entry s+1+P; gap entry s+1+P+U; next pre or done at s+1+P+U+G (P/U/G after 0→1 substitution).
- run_done coincides with first RUN_DONE cycle; busy drops same cycle.
- Async reset mid-run: immediate return to reset values; no ABORT strobe.

## Structure
- ups_pkg: state_t, mode constants (MODE_IDLE/LB/DAC/RUN), loop-counter width.
- Sub-module ups_phase_timer: loadable down-counter (CNT_W), load value with 0→1 substitution, one-cycle expire pulse; sequencer uses one instance.
- Loopback alignment as a function in ups_pkg.

## Test plan
- Reset then mode=1, adc=0xABC adc_dv → all dac=0xABC, dac_dv=all 1 one cycle later; with ADC_W=14, adc=0x3FFF → dac=0xFFF.
- mode=2, test_dv=2'b10, ch1=0x123 → only dac_dv[1], dac ch1=0x123; simultaneous both strobes → both load.
- mode=3, mask=2'b01, base=0x100, pre=0x200/len 3, pulse=0xF00/len 5, gap len 4, loops=2 → ch0 sequence 0x100,0x200×3,0xF00×5,0x100×4 twice, run_done at 1+2×12; ch1 never strobes.
- Run with pulse_len=0 → pulse phase lasts exactly 1 cycle.
- mode_update during RUN_PULSE → next cycle all dac 0, dac_dv all 1; IDLE following cycle; busy 0.
- rst_n low mid-run for 1 cycle asynchronously → outputs 0 immediately, state IDLE, no run_done.
